// File: rtl/inv_key_expansion_control.sv
// Byte-serial AES-128 inverse key schedule: loads the round-10 key, then streams round keys 10..0.
// Optional OUT_BYTE_REG_EN adds one register stage on out_valid/output_key.
module inv_key_expansion_control (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [7:0]   input_key,
  output logic         out_valid,
  output logic [7:0]   output_key,
  output logic [127:0] output_key1,
  output logic [3:0]   round,
  output logic         busy,
  output logic         done
);
  typedef enum logic [2:0] {IDLE, LOAD, EMIT, GEN, DONE} state_t;

  state_t       state_reg, state_next;
  logic [127:0] key_reg, key_next;
  logic [3:0]   cnt_reg, cnt_next;
  logic [3:0]   round_reg, round_next;
  logic [7:0]   key_bytes [16];
  logic [7:0]   sbox_in, sbox_out, rcon;
  logic         byte_valid;
  logic [7:0]   byte_data;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_lane
      assign key_bytes[gi] = key_reg[127-8*gi -: 8];
    end
  endgenerate

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as a^254 (multiplicative inverse) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p, sq;
    p  = 8'h01;
    sq = a;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      p  = gf_mul(p, sq);
    end
    return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
  endfunction

  always_comb begin
    rcon = 8'h00;
    case (round_reg)
      4'd10: rcon = 8'h36;
      4'd9:  rcon = 8'h1b;
      4'd8:  rcon = 8'h80;
      4'd7:  rcon = 8'h40;
      4'd6:  rcon = 8'h20;
      4'd5:  rcon = 8'h10;
      4'd4:  rcon = 8'h08;
      4'd3:  rcon = 8'h04;
      4'd2:  rcon = 8'h02;
      4'd1:  rcon = 8'h01;
      default: rcon = 8'h00;
    endcase
  end

  // GEN step k (1..4) feeds RotWord(w3) byte k-1, i.e. w3 byte k mod 4
  assign sbox_in  = key_bytes[{2'b11, cnt_reg[1:0]}];
  assign sbox_out = sbox(sbox_in);

  always_comb begin
    state_next = state_reg;
    key_next   = key_reg;
    cnt_next   = cnt_reg;
    round_next = round_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (in_valid) begin
          key_next[127:120] = input_key;
          cnt_next          = 4'd1;
          state_next        = LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          for (int b = 0; b < 16; b++)
            if (cnt_reg == 4'(b)) key_next[127-8*b -: 8] = input_key;
          cnt_next = cnt_reg + 4'd1;
          if (cnt_reg == 4'd15) begin
            state_next = EMIT;
            round_next = 4'd10;
            cnt_next   = 4'd0;
          end
        end
      end
      EMIT: begin
        cnt_next = cnt_reg + 4'd1;
        if (cnt_reg == 4'd15) begin
          cnt_next   = 4'd0;
          state_next = (round_reg == 4'd0) ? DONE : GEN;
        end
      end
      GEN: begin
        cnt_next = cnt_reg + 4'd1;
        if (cnt_reg == 4'd0) begin
          key_next[95:0] = {key_reg[95:64] ^ key_reg[127:96],
                            key_reg[63:32] ^ key_reg[95:64],
                            key_reg[31:0]  ^ key_reg[63:32]};
        end else begin
          for (int b = 0; b < 4; b++)
            if (cnt_reg == 4'(b + 1))
              key_next[127-8*b -: 8] = key_bytes[b] ^ sbox_out ^ ((b == 0) ? rcon : 8'h00);
        end
        if (cnt_reg == 4'd4) begin
          cnt_next   = 4'd0;
          round_next = round_reg - 4'd1;
          state_next = EMIT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      key_reg   <= '0;
      cnt_reg   <= '0;
      round_reg <= '0;
    end else begin
      state_reg <= state_next;
      key_reg   <= key_next;
      cnt_reg   <= cnt_next;
      round_reg <= round_next;
    end
  end

  assign byte_valid  = (state_reg == EMIT);
  assign byte_data   = byte_valid ? key_bytes[cnt_reg] : 8'h00;
  assign output_key1 = key_reg;
  assign round       = round_reg;
  assign busy        = (state_reg == LOAD) || (state_reg == EMIT) || (state_reg == GEN);
  assign done        = (state_reg == DONE);

`ifdef OUT_BYTE_REG_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      output_key <= 8'h00;
    end else begin
      out_valid  <= byte_valid;
      output_key <= byte_data;
    end
  end
`else
  assign out_valid  = byte_valid;
  assign output_key = byte_data;
`endif

endmodule

// File: tb/tb_inv_key_expansion_control.sv
// Self-checking bench for inv_key_expansion_control: word-level inverse key schedule model
// plus a per-cycle timing model indexed by cycles since the first streamed byte.
`timescale 1ns/1ps
module tb_inv_key_expansion_control;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [7:0]   input_key = 8'h00;
  logic         out_valid;
  logic [7:0]   output_key;
  logic [127:0] output_key1;
  logic [3:0]   round;
  logic         busy;
  logic         done;

  inv_key_expansion_control dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .input_key(input_key),
    .out_valid(out_valid), .output_key(output_key), .output_key1(output_key1),
    .round(round), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

`ifdef OUT_BYTE_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif
  localparam logic [127:0] KEY10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam int RUN_LEN = 11*16 + 10*5;   // cycles from first byte to DONE

  int           errors = 0;
  int           checks = 0;
  logic [7:0]   sbox_t [256];
  logic [127:0] rk [11];
  bit           run_active = 1'b0;
  int           pos = 0;
  int           ov_seen = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (pos %0d)", name, act, exp, pos);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // S-box by brute-force inverse search and the bitwise affine formula; then undo the key schedule
  task automatic build_model();
    logic [7:0]  inv, c, s, rc;
    logic [31:0] w0, w1, w2, w3;
    c = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[a] = s;
    end
    rk[10] = KEY10;
    for (int r = 10; r >= 1; r--) begin
      {w0, w1, w2, w3} = rk[r];
      w3 = w3 ^ w2;
      w2 = w2 ^ w1;
      w1 = w1 ^ w0;
      rc = 8'h01;
      for (int i = 1; i < r; i++) rc = xt(rc);
      w0 = w0 ^ sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
      rk[r-1] = {w0, w1, w2, w3};
    end
  endtask

  always @(negedge clk) begin : cmp
    int q, j, rr, rq;
    bit exp_ov;
    logic [127:0] t;
    if (run_active) begin
      rr = (pos < RUN_LEN) ? 10 - pos/21 : 0;
      check("busy", 128'(busy), 128'(pos < RUN_LEN));
      check("done", 128'(done), 128'(pos >= RUN_LEN));
      check("round", 128'(round), 128'(rr));
      if (pos < RUN_LEN && pos % 21 < 16) check("output_key1", output_key1, rk[rr]);
      q = pos - LAT;
      exp_ov = (q >= 0) && (q < RUN_LEN) && (q % 21 < 16);
      check("out_valid", 128'(out_valid), 128'(exp_ov));
      if (exp_ov) begin
        j  = q % 21;
        rq = 10 - q/21;
        t  = rk[rq] >> (8*(15-j));
        check("output_key", 128'(output_key), 128'(t[7:0]));
        if (j == 15) $display("round %0d key %h streamed", rq, rk[rq]);
      end
      if (out_valid) ov_seen++;
      if (pos == RUN_LEN + 4) run_active = 1'b0;
      pos++;
    end
  end

  task automatic load_key(input int gap, input bit junk);
    logic [127:0] kb;
    for (int i = 0; i < 16; i++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        in_valid  = 1'b0;
        input_key = 8'($urandom);
      end
      @(negedge clk);
      if (i == 8) check("busy_load", 128'(busy), 128'(1));
      kb = KEY10 >> (8*(15-i));
      in_valid  = 1'b1;
      input_key = kb[7:0];
    end
    @(posedge clk);
    pos        = 0;
    ov_seen    = 0;
    run_active = 1'b1;
    #1;
    if (!junk) in_valid = 1'b0;
  endtask

  task automatic finish_run(input bit junk);
    int c;
    c = 0;
    if (junk) begin
      repeat (RUN_LEN - 5) begin
        @(negedge clk);
        in_valid  = 1'b1;
        input_key = 8'($urandom);
      end
      @(negedge clk);
      in_valid = 1'b0;
    end
    while (run_active && c < 400) begin
      @(posedge clk);
      c++;
    end
    if (run_active) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: got active expected finished after %0d cycles", c);
      run_active = 1'b0;
    end
    check("out_valid_count", 128'(ov_seen), 128'(176));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    check({tag, "_output_key"}, 128'(output_key), 128'(0));
    check({tag, "_output_key1"}, output_key1, 128'(0));
    check({tag, "_round"}, 128'(round), 128'(0));
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_done"}, 128'(done), 128'(0));
  endtask

  initial begin
    build_model();
    check("model_sbox_00", 128'(sbox_t[0]), 128'(8'h63));
    check("model_sbox_53", 128'(sbox_t[8'h53]), 128'(8'hed));
    check("model_rk9", rk[9], 128'hac7766f319fadc2128d12941575c006e);
    check("model_rk1", rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("model_rk0", rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

    // reset with in_valid asserted must be ignored
    rst       = 1'b0;
    in_valid  = 1'b1;
    input_key = 8'hff;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("idle_busy", 128'(busy), 128'(0));
    check("idle_done", 128'(done), 128'(0));

    // FIPS-197 key, back-to-back load
    load_key(0, 1'b0);
    finish_run(1'b0);
    check("done_key", output_key1, 128'h2b7e151628aed2a6abf7158809cf4f3c);

    // load with a byte every third cycle, restarted from DONE
    load_key(2, 1'b0);
    finish_run(1'b0);

    // junk in_valid traffic while streaming
    load_key(0, 1'b1);
    finish_run(1'b1);

    // reset in the middle of GEN at round 6, then a fresh load
    load_key(0, 1'b0);
    repeat (102) @(negedge clk);
    run_active = 1'b0;
    check("gen_round", 128'(round), 128'(6));
    check("gen_busy", 128'(busy), 128'(1));
    check("gen_out_valid", 128'(out_valid), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("midgen_reset");
    rst = 1'b1;
    load_key(1, 1'b0);
    finish_run(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
